// File: rtl/spi_dev_demux.sv
// 1:NUM_DEV SPI bus router: latches a target device per transaction, guards CS
// setup/hold around each frame, forwards master pins to one device and counts SCLK edges.
module spi_dev_demux #(
  parameter int   NUM_DEV   = 4,
  parameter int   SEL_W     = 2,
  parameter int   SETUP_CYC = 2,
  parameter int   HOLD_CYC  = 2,
  parameter logic CPOL      = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [SEL_W-1:0]   sel_in,
  output logic               grant,
  output logic               busy,
  output logic               sel_err,
  output logic [SEL_W-1:0]   cur_sel,
  output logic [CNT_W-1:0]   bit_cnt,
  input  logic               m_cs_n,
  input  logic               m_sclk,
  input  logic               m_mosi,
  output logic               m_miso,
  output logic [NUM_DEV-1:0] dev_cs_n,
  output logic [NUM_DEV-1:0] dev_sclk,
  output logic [NUM_DEV-1:0] dev_mosi,
  input  logic [NUM_DEV-1:0] dev_miso
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [SEL_W:0] NUM_DEV_L = (SEL_W+1)'(NUM_DEV);
  localparam logic [3:0]     SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0]     HOLD_LD   = 4'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sel_err_q, sel_err_d;
  logic             grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             cs_seen_q, cs_seen_d;
  logic             m_cs_n_q, m_cs_n_d;
  logic             m_sclk_q, m_sclk_d;
  logic             sel_ok_s;
  logic             cs_rise_s;
  logic             sclk_rise_s;

  assign sel_ok_s    = ({1'b0, sel_in} < NUM_DEV_L);
  assign cs_rise_s   = m_cs_n & ~m_cs_n_q;
  assign sclk_rise_s = m_sclk & ~m_sclk_q;

  // Next-state, guard counter, device latch and bit counter
  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    cur_sel_d = cur_sel_q;
    bit_cnt_d = bit_cnt_q;
    sel_err_d = 1'b0;
    cs_seen_d = cs_seen_q;
    m_cs_n_d  = m_cs_n;
    m_sclk_d  = m_sclk;
    case (state_q)
      ST_IDLE: begin
        if (req && sel_ok_s) begin
          cur_sel_d = sel_in;
          bit_cnt_d = '0;
          gcnt_d    = SETUP_LD;
          cs_seen_d = 1'b0;
          state_d   = ST_SETUP;
        end else if (req) begin
          sel_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (gcnt_q == 4'd0) begin
          state_d = ST_ACTIVE;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (!m_cs_n) begin
          cs_seen_d = 1'b1;
        end else begin
          cs_seen_d = cs_seen_q;
        end
        if (!m_cs_n && sclk_rise_s && (bit_cnt_q != {CNT_W{1'b1}})) begin
          bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        // A drop of req is honoured only between frames (CS high)
        if ((cs_seen_q && cs_rise_s) || (!req && m_cs_n)) begin
          gcnt_d  = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_HOLD: begin
        if (gcnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    grant_d = (state_d == ST_ACTIVE);
    busy_d  = (state_d != ST_IDLE);
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gcnt_q    <= 4'd0;
      cur_sel_q <= '0;
      bit_cnt_q <= '0;
      sel_err_q <= 1'b0;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      cs_seen_q <= 1'b0;
      m_cs_n_q  <= 1'b1;
      m_sclk_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gcnt_q    <= gcnt_d;
      cur_sel_q <= cur_sel_d;
      bit_cnt_q <= bit_cnt_d;
      sel_err_q <= sel_err_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      cs_seen_q <= cs_seen_d;
      m_cs_n_q  <= m_cs_n_d;
      m_sclk_q  <= m_sclk_d;
    end
  end

  // Zero-latency pin forwarding; only the latched device sees the master in ACTIVE
  always_comb begin
    dev_cs_n = {NUM_DEV{1'b1}};
    dev_sclk = {NUM_DEV{CPOL}};
    dev_mosi = {NUM_DEV{1'b0}};
    m_miso   = 1'b0;
    if (state_q == ST_ACTIVE) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        if (cur_sel_q == SEL_W'(i)) begin
          dev_cs_n[i] = m_cs_n;
          dev_sclk[i] = m_sclk;
          dev_mosi[i] = m_mosi;
          if (!m_cs_n) begin
            m_miso = dev_miso[i];
          end else begin
            m_miso = 1'b0;
          end
        end else begin
          dev_cs_n[i] = 1'b1;
        end
      end
    end else begin
      m_miso = 1'b0;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign sel_err = sel_err_q;
  assign cur_sel = cur_sel_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_spi_dev_demux.sv
// Directed bench for spi_dev_demux: a 4-device/8-bit instance and a 3-device/4-bit
// instance share the master SPI pins; expected values are hand-computed constants.
module tb_spi_dev_demux;

  logic       clk;
  logic       rst_n;
  logic       m_cs_n, m_sclk, m_mosi;

  logic       req;
  logic [1:0] sel_in;
  logic       grant, busy, sel_err, m_miso;
  logic [1:0] cur_sel;
  logic [7:0] bit_cnt;
  logic [3:0] dev_cs_n, dev_sclk, dev_mosi, dev_miso;

  logic       req3;
  logic [1:0] sel3;
  logic       grant3, busy3, sel_err3, m_miso3;
  logic [1:0] cur_sel3;
  logic [3:0] bit_cnt3;
  logic [2:0] dev_cs_n3, dev_sclk3, dev_mosi3;
  logic [2:0] dev_miso3;

  int n_tests = 0;
  int n_fail  = 0;

  spi_dev_demux u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel_in(sel_in),
    .grant(grant), .busy(busy), .sel_err(sel_err), .cur_sel(cur_sel), .bit_cnt(bit_cnt),
    .m_cs_n(m_cs_n), .m_sclk(m_sclk), .m_mosi(m_mosi), .m_miso(m_miso),
    .dev_cs_n(dev_cs_n), .dev_sclk(dev_sclk), .dev_mosi(dev_mosi), .dev_miso(dev_miso)
  );

  spi_dev_demux #(.NUM_DEV(3), .SEL_W(2), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .sel_in(sel3),
    .grant(grant3), .busy(busy3), .sel_err(sel_err3), .cur_sel(cur_sel3), .bit_cnt(bit_cnt3),
    .m_cs_n(m_cs_n), .m_sclk(m_sclk), .m_mosi(m_mosi), .m_miso(m_miso3),
    .dev_cs_n(dev_cs_n3), .dev_sclk(dev_sclk3), .dev_mosi(dev_mosi3), .dev_miso(dev_miso3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one master frame on the shared pins; sel < 0 means no device of u_dut is targeted.
  task automatic run_frame(input int sel, input int nbits, input logic [31:0] pat,
                           output logic [31:0] miso_cap, output logic [3:0] other_act,
                           output int mosi_err, output logic [3:0] cs_snap);
    logic [3:0] onehot;
    logic       b;
    onehot    = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
    miso_cap  = 32'h0;
    other_act = 4'b0000;
    mosi_err  = 0;
    cs_snap   = 4'b1111;
    m_cs_n    = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      b        = pat[nbits-1-i];
      m_sclk   = 1'b0;
      m_mosi   = ~b;
      dev_miso = {4{~b}};
      if (sel >= 0) dev_miso[sel] = b;
      @(negedge clk);
      m_sclk = 1'b1;
      #1;
      miso_cap  = {miso_cap[30:0], m_miso};
      other_act = other_act | ((~dev_cs_n | dev_sclk | dev_mosi) & ~onehot);
      if (sel >= 0) begin
        if (dev_mosi[sel] !== m_mosi || dev_sclk[sel] !== 1'b1) mosi_err++;
      end
      if (i == 0) cs_snap = dev_cs_n;
    end
    @(negedge clk);
    m_sclk = 1'b0;
    @(negedge clk);
    m_cs_n = 1'b1;
  endtask

  logic [31:0] cap;
  logic [3:0]  oth, cs_s;
  int          merr;
  int          err_cnt;

  initial begin
    rst_n = 1'b0; req = 1'b0; sel_in = 2'd0; req3 = 1'b0; sel3 = 2'd0;
    m_cs_n = 1'b1; m_sclk = 1'b0; m_mosi = 1'b0; dev_miso = 4'b0000; dev_miso3 = 3'b000;
    repeat (2) @(negedge clk);
    check_eq("rst_grant", {31'd0, grant}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sel_err", {31'd0, sel_err}, 32'd0);
    check_eq("rst_cur_sel", {30'd0, cur_sel}, 32'd0);
    check_eq("rst_bit_cnt", {24'd0, bit_cnt}, 32'd0);
    check_eq("rst_dev_pins", {20'd0, dev_cs_n, dev_sclk, dev_mosi}, 32'h0000_0f00);
    check_eq("rst_miso", {31'd0, m_miso}, 32'd0);
    rst_n = 1'b1;

    // Normal frame on device 2
    @(negedge clk);
    req = 1'b1; sel_in = 2'd2;
    @(negedge clk);
    check_eq("nf_busy_setup", {31'd0, busy}, 32'd1);
    check_eq("nf_grant_c1", {31'd0, grant}, 32'd0);
    check_eq("nf_cur_sel", {30'd0, cur_sel}, 32'd2);
    @(negedge clk);
    check_eq("nf_grant_c2", {31'd0, grant}, 32'd0);
    sel_in = 2'd0;
    @(negedge clk);
    check_eq("nf_grant_c3", {31'd0, grant}, 32'd1);
    check_eq("nf_sel_ignored", {30'd0, cur_sel}, 32'd2);
    run_frame(2, 24, 32'h00A5_A5A5, cap, oth, merr, cs_s);
    req = 1'b0;
    check_eq("nf_miso_pattern", cap, 32'h00A5_A5A5);
    check_eq("nf_other_idle", {28'd0, oth}, 32'd0);
    check_eq("nf_mosi_fwd", merr, 32'd0);
    check_eq("nf_cs_fwd", {28'd0, cs_s}, 32'h0000_000b);
    check_eq("nf_bit_cnt", {24'd0, bit_cnt}, 32'd24);
    @(negedge clk);
    check_eq("nf_hold_grant", {31'd0, grant}, 32'd0);
    check_eq("nf_hold_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("nf_hold2_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("nf_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("nf_cnt_held", {24'd0, bit_cnt}, 32'd24);

    // Back-to-back: frame stays on device 1 although sel_in moves to 0
    req = 1'b1; sel_in = 2'd1;
    repeat (3) @(negedge clk);
    check_eq("bb_grant1", {31'd0, grant}, 32'd1);
    sel_in = 2'd0;
    run_frame(1, 8, 32'h0000_003C, cap, oth, merr, cs_s);
    check_eq("bb_miso1", cap, 32'h0000_003C);
    check_eq("bb_cs1", {28'd0, cs_s}, 32'h0000_000d);
    check_eq("bb_other1", {28'd0, oth}, 32'd0);
    @(negedge clk);
    check_eq("bb_hold_busy", {30'd0, busy, grant}, 32'd2);
    m_cs_n = 1'b0;
    #1;
    check_eq("bb_hold_cs_blocked", {28'd0, dev_cs_n}, 32'h0000_000f);
    @(negedge clk);
    check_eq("bb_hold2_busy", {31'd0, busy}, 32'd1);
    m_cs_n = 1'b1;
    @(negedge clk);
    check_eq("bb_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("bb_reaccept", {29'd0, busy, cur_sel}, 32'd4);
    @(negedge clk);
    check_eq("bb_grant0_c2", {31'd0, grant}, 32'd0);
    @(negedge clk);
    check_eq("bb_grant0_c3", {31'd0, grant}, 32'd1);
    req = 1'b0;
    run_frame(0, 8, 32'h0000_0096, cap, oth, merr, cs_s);
    check_eq("bb_miso0", cap, 32'h0000_0096);
    check_eq("bb_cs0", {28'd0, cs_s}, 32'h0000_000e);
    check_eq("bb_cnt0", {24'd0, bit_cnt}, 32'd8);
    repeat (3) @(negedge clk);
    check_eq("bb_end_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("bb_stay_idle", {31'd0, busy}, 32'd0);

    // Abort: req dropped with CS high after grant
    req = 1'b1; sel_in = 2'd3;
    repeat (3) @(negedge clk);
    check_eq("ab_grant", {31'd0, grant}, 32'd1);
    req = 1'b0;
    @(negedge clk);
    check_eq("ab_hold", {30'd0, busy, grant}, 32'd2);
    check_eq("ab_cs", {28'd0, dev_cs_n}, 32'h0000_000f);
    @(negedge clk);
    check_eq("ab_hold2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("ab_idle", {31'd0, busy}, 32'd0);
    check_eq("ab_cnt", {24'd0, bit_cnt}, 32'd0);

    // Bad select on the 3-device instance
    req3 = 1'b1; sel3 = 2'd3;
    err_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sel_err3) err_cnt++;
      if (i == 1) begin
        check_eq("bs_busy", {31'd0, busy3}, 32'd0);
        check_eq("bs_cs", {29'd0, dev_cs_n3}, 32'h0000_0007);
      end
      if (i == 2) req3 = 1'b0;
    end
    check_eq("bs_err_cycles", err_cnt, 32'd3);
    check_eq("bs_err_off", {31'd0, sel_err3}, 32'd0);

    // Saturation on the 4-bit counter; u_dut idle must not forward the master
    req3 = 1'b1; sel3 = 2'd1;
    repeat (3) @(negedge clk);
    check_eq("sat_grant", {31'd0, grant3}, 32'd1);
    run_frame(-1, 20, 32'h0000_0000, cap, oth, merr, cs_s);
    req3 = 1'b0;
    check_eq("sat_bit_cnt", {28'd0, bit_cnt3}, 32'd15);
    check_eq("sat_idle_blocked", {28'd0, oth}, 32'd0);
    repeat (4) @(negedge clk);

    // Async reset in the middle of an active frame on device 2
    req = 1'b1; sel_in = 2'd2;
    repeat (3) @(negedge clk);
    m_cs_n = 1'b0;
    @(negedge clk); m_sclk = 1'b1;
    @(negedge clk); m_sclk = 1'b0;
    #1;
    check_eq("mr_pre_cs", {28'd0, dev_cs_n}, 32'h0000_000b);
    check_eq("mr_pre_cnt", {24'd0, bit_cnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mr_cs", {28'd0, dev_cs_n}, 32'h0000_000f);
    check_eq("mr_grant", {31'd0, grant}, 32'd0);
    check_eq("mr_cnt", {24'd0, bit_cnt}, 32'd0);
    check_eq("mr_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    req = 1'b0; m_cs_n = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
